// File: rtl/matrix_add_share_scheduler.sv
// Round-robin, credit-limited scheduler that shares one non-stalling MatrixAdd core
// among N_REQ requesters and returns ID-tagged results through a result FIFO.
module matrix_add_share_scheduler #(
  parameter int N_REQ   = 4,
  parameter int IN_W    = 3840,
  parameter int OUT_W   = 2040,
  parameter int CREDITS = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_REQ-1:0]      s_valid,
  input  logic [N_REQ*IN_W-1:0] s_data,
  output logic [N_REQ-1:0]      s_ready,
  output logic                  core_in_ready,
  output logic [IN_W-1:0]       core_in_data,
  input  logic                  core_out_ready,
  input  logic [OUT_W-1:0]      core_out_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_W-1:0]      m_data,
  output logic [ID_W-1:0]       m_id,
  output logic                  busy,
  output logic                  err_unexp
);

  localparam int PTR_W = (CREDITS > 1) ? $clog2(CREDITS) : 1;
  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CREDITS_C = CNT_W'(CREDITS);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] credit_q, credit_d;
  logic             core_in_ready_q, core_in_ready_d;
  logic [IN_W-1:0]  core_in_data_q, core_in_data_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [ID_W-1:0]  tag_mem_q [CREDITS];
  logic [ID_W-1:0]  tag_mem_d [CREDITS];
  logic [PTR_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CNT_W-1:0] tag_cnt_q, tag_cnt_d;

  logic [OUT_W-1:0] res_data_q [CREDITS];
  logic [OUT_W-1:0] res_data_d [CREDITS];
  logic [ID_W-1:0]  res_id_q [CREDITS];
  logic [ID_W-1:0]  res_id_d [CREDITS];
  logic [PTR_W-1:0] res_wr_q, res_wr_d, res_rd_q, res_rd_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

  logic             can_grant_s, grant_vld_s, hit_s;
  logic [ID_W-1:0]  grant_idx_s, cand_s;
  logic [IN_W-1:0]  sel_data_s;
  logic             tag_pop_s, unexp_s, res_pop_s;

  assign can_grant_s = enable & ~reset & (credit_q != {CNT_W{1'b0}});
  assign tag_pop_s   = core_out_ready & (tag_cnt_q != {CNT_W{1'b0}});
  assign unexp_s     = core_out_ready & (tag_cnt_q == {CNT_W{1'b0}});
  assign res_pop_s   = m_valid & m_ready;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s      = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      hit_s       = can_grant_s & ~grant_vld_s & s_valid[cand_s];
      grant_idx_s = hit_s ? cand_s : grant_idx_s;
      grant_vld_s = grant_vld_s | hit_s;
    end
  end

  // One-hot grant and operand mux for the granted requester.
  always_comb begin
    s_ready              = '0;
    s_ready[grant_idx_s] = grant_vld_s;
    sel_data_s           = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_data_s = (grant_idx_s == ID_W'(i)) ? s_data[i*IN_W +: IN_W] : sel_data_s;
    end
  end

  // Issue, pointer and credit bookkeeping.
  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    core_in_data_d  = core_in_data_q;
    core_in_ready_d = grant_vld_s;
    credit_d        = credit_q;
    if (grant_vld_s) begin
      rr_ptr_d       = grant_idx_s;
      core_in_data_d = sel_data_s;
    end else begin
      rr_ptr_d       = rr_ptr_q;
      core_in_data_d = core_in_data_q;
    end
    case ({grant_vld_s, res_pop_s})
      2'b10:   credit_d = credit_q - CNT_W'(1);
      2'b01:   credit_d = credit_q + CNT_W'(1);
      default: credit_d = credit_q;
    endcase
    busy_d = (credit_d != CREDITS_C);
    err_d  = err_q | unexp_s;
  end

  // Tag FIFO: requester IDs of operations issued but not yet returned by the core.
  always_comb begin
    tag_mem_d = tag_mem_q;
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    tag_cnt_d = tag_cnt_q;
    if (grant_vld_s) begin
      tag_mem_d[tag_wr_q] = grant_idx_s;
      tag_wr_d            = tag_wr_q + PTR_W'(1);
    end else begin
      tag_wr_d = tag_wr_q;
    end
    if (tag_pop_s) begin
      tag_rd_d = tag_rd_q + PTR_W'(1);
    end else begin
      tag_rd_d = tag_rd_q;
    end
    case ({grant_vld_s, tag_pop_s})
      2'b10:   tag_cnt_d = tag_cnt_q + CNT_W'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - CNT_W'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase
  end

  // Result FIFO: occupancy is bounded by the credit count, so no full check.
  always_comb begin
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    res_wr_d   = res_wr_q;
    res_rd_d   = res_rd_q;
    res_cnt_d  = res_cnt_q;
    if (tag_pop_s) begin
      res_data_d[res_wr_q] = core_out_data;
      res_id_d[res_wr_q]   = tag_mem_q[tag_rd_q];
      res_wr_d             = res_wr_q + PTR_W'(1);
    end else begin
      res_wr_d = res_wr_q;
    end
    if (res_pop_s) begin
      res_rd_d = res_rd_q + PTR_W'(1);
    end else begin
      res_rd_d = res_rd_q;
    end
    case ({tag_pop_s, res_pop_s})
      2'b10:   res_cnt_d = res_cnt_q + CNT_W'(1);
      2'b01:   res_cnt_d = res_cnt_q - CNT_W'(1);
      default: res_cnt_d = res_cnt_q;
    endcase
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q        <= LAST_ID;
      credit_q        <= CREDITS_C;
      core_in_ready_q <= 1'b0;
      core_in_data_q  <= '0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
      tag_mem_q       <= '{default: '0};
      tag_wr_q        <= '0;
      tag_rd_q        <= '0;
      tag_cnt_q       <= '0;
      res_data_q      <= '{default: '0};
      res_id_q        <= '{default: '0};
      res_wr_q        <= '0;
      res_rd_q        <= '0;
      res_cnt_q       <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      credit_q        <= credit_d;
      core_in_ready_q <= core_in_ready_d;
      core_in_data_q  <= core_in_data_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
      tag_mem_q       <= tag_mem_d;
      tag_wr_q        <= tag_wr_d;
      tag_rd_q        <= tag_rd_d;
      tag_cnt_q       <= tag_cnt_d;
      res_data_q      <= res_data_d;
      res_id_q        <= res_id_d;
      res_wr_q        <= res_wr_d;
      res_rd_q        <= res_rd_d;
      res_cnt_q       <= res_cnt_d;
    end
  end

  assign core_in_ready = core_in_ready_q;
  assign core_in_data  = core_in_data_q;
  assign m_valid       = (res_cnt_q != {CNT_W{1'b0}});
  assign m_data        = res_data_q[res_rd_q];
  assign m_id          = res_id_q[res_rd_q];
  assign busy          = busy_q;
  assign err_unexp     = err_q;

endmodule

// File: tb/tb_matrix_add_share_scheduler.sv
// Directed bench for matrix_add_share_scheduler with a latency-3 stub core (16-bit
// elements, 17-bit sums) and a queue scoreboard checked by a separate monitor.
module tb_matrix_add_share_scheduler;
  localparam int N_REQ = 4, IN_W = 3840, OUT_W = 2040, CREDITS = 4, ID_W = 2, NEL = 120;

  logic                  clk, reset, enable, m_ready, spur;
  logic [N_REQ-1:0]      s_valid, s_ready;
  logic [N_REQ*IN_W-1:0] s_data;
  logic                  core_in_ready, core_out_ready, m_valid, busy, err_unexp;
  logic [IN_W-1:0]       core_in_data;
  logic [OUT_W-1:0]      core_out_data, m_data;
  logic [ID_W-1:0]       m_id;

  logic [15:0]      a_val [N_REQ];
  logic [15:0]      b_val [N_REQ];
  logic [2:0]       stg_v;
  logic [OUT_W-1:0] stg_d [3];
  logic [ID_W-1:0]  q_id [$];
  logic [OUT_W-1:0] q_dat [$];
  int n_cmp, n_err, grants, n, ex;

  matrix_add_share_scheduler #(.N_REQ(N_REQ), .IN_W(IN_W), .OUT_W(OUT_W),
                               .CREDITS(CREDITS), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .core_in_ready(core_in_ready), .core_in_data(core_in_data),
    .core_out_ready(core_out_ready), .core_out_data(core_out_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_id(m_id), .busy(busy), .err_unexp(err_unexp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] core_sum(input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int e = 0; e < NEL; e++)
      r[e*17 +: 17] = {1'b0, d[e*16 +: 16]} + {1'b0, d[1920 + e*16 +: 16]};
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] rep17(input logic [16:0] v);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int e = 0; e < NEL; e++) r[e*17 +: 17] = v;
    return r;
  endfunction

  always_comb begin
    s_data = '0;
    for (int i = 0; i < N_REQ; i++)
      for (int e = 0; e < NEL; e++) begin
        s_data[i*IN_W + e*16 +: 16]        = a_val[i];
        s_data[i*IN_W + 1920 + e*16 +: 16] = b_val[i];
      end
  end

  // Stub core: fixed three-cycle latency, shares the scheduler reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_v <= 3'b000;
      stg_d <= '{default: '0};
    end else begin
      stg_v    <= {stg_v[1:0], core_in_ready};
      stg_d[0] <= core_sum(core_in_data);
      stg_d[1] <= stg_d[0];
      stg_d[2] <= stg_d[1];
    end
  end
  assign core_out_ready = stg_v[2] | spur;
  assign core_out_data  = stg_d[2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance one cycle; operands of granted requesters change so each issue is distinct.
  task automatic tick();
    logic [N_REQ-1:0] hs;
    #1;
    hs = s_valid & s_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++)
      if (hs[i]) begin
        a_val[i] = a_val[i] + 16'd5;
        b_val[i] = b_val[i] + 16'd3;
      end
  endtask

  task automatic do_reset();
    reset = 1'b1; s_valid = 4'b0000; m_ready = 1'b0; enable = 1'b1; spur = 1'b0;
    q_id.delete(); q_dat.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 60) begin tick(); k++; end
    check(nm, 64'(busy), 64'(0));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; s_valid = 4'b1111; m_ready = 1'b0; spur = 1'b0;
    n_cmp = 0; n_err = 0;
    for (int i = 0; i < N_REQ; i++) begin
      a_val[i] = 16'(i * 10 + 1);
      b_val[i] = 16'(i + 5);
    end
    fork
      // Capture side: expected result pushed at each handshake.
      forever begin
        @(negedge clk);
        if (!reset)
          for (int i = 0; i < N_REQ; i++)
            if (s_valid[i] && s_ready[i]) begin
              q_id.push_back(ID_W'(i));
              q_dat.push_back(rep17({1'b0, a_val[i]} + {1'b0, b_val[i]}));
            end
      end
      // Monitor: compares each accepted output against the scoreboard head.
      forever begin
        @(negedge clk);
        if (!reset && m_valid && m_ready) begin
          n_cmp++;
          if (q_id.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got id %0d with no expected entry", m_id);
          end else begin
            logic [ID_W-1:0]  eid;
            logic [OUT_W-1:0] edat;
            eid  = q_id.pop_front();
            edat = q_dat.pop_front();
            if (m_id !== eid || m_data !== edat) begin
              n_err++;
              $display("FAIL sb_result: got id %0d data[31:0] %h, expected id %0d data[31:0] %h",
                       m_id, m_data[31:0], eid, edat[31:0]);
            end
          end
        end
      end
      begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values (s_valid held high to show grants are blocked in reset).
    #1;
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_cin_rdy", 64'(core_in_ready), 64'(0));
    check("rst_cin_dat", 64'(core_in_data[63:0]), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_id", 64'(m_id), 64'(0));
    check("rst_m_data", 64'(m_data[63:0]), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err_unexp), 64'(0));
    do_reset();

    // Single request from requester 2: operands 1 and 2, sum 3.
    a_val[2] = 16'd1; b_val[2] = 16'd2; s_valid = 4'b0100;
    #1;
    check("t1_grant", 64'(s_ready), 64'(4'b0100));
    tick();
    s_valid = 4'b0000;
    check("t1_pulse", 64'(core_in_ready), 64'(1));
    check("t1_cin_a", 64'(core_in_data[15:0]), 64'(1));
    check("t1_cin_b", 64'(core_in_data[1935:1920]), 64'(2));
    check("t1_busy", 64'(busy), 64'(1));
    tick();
    check("t1_pulse_end", 64'(core_in_ready), 64'(0));
    n = 2;
    while (!m_valid && n < 20) begin tick(); n++; end
    check("t1_latency", 64'(n), 64'(5));
    check("t1_m_id", 64'(m_id), 64'(2));
    check("t1_sum_lo", 64'(m_data[16:0]), 64'(3));
    check("t1_sum_hi", 64'(m_data[OUT_W-1 -: 17]), 64'(3));
    m_ready = 1'b1;
    tick();
    check("t1_drained", 64'(m_valid), 64'(0));
    check("t1_busy_end", 64'(busy), 64'(0));

    // Fairness: all requesters valid, downstream always ready.
    do_reset();
    m_ready = 1'b1; s_valid = 4'b1111; ex = 0; grants = 0;
    #1;
    for (int c = 0; c < 24; c++) begin
      if (c < 4) check("t2_b2b", 64'(s_ready), 64'(1 << c));
      if (s_ready != 4'b0000) begin
        check("t2_order", 64'(s_ready), 64'(1 << ex));
        ex = (ex + 1) % N_REQ;
        grants++;
      end
      tick();
    end
    check("t2_grants", 64'(grants), 64'(16));
    s_valid = 4'b0000;
    wait_idle("t2_idle");

    // Credit exhaustion and simultaneous grant/pop.
    do_reset();
    s_valid = 4'b1111; grants = 0;
    repeat (10) begin
      #1;
      if (s_ready != 4'b0000) grants++;
      tick();
    end
    check("t3_grants", 64'(grants), 64'(4));
    check("t3_blocked", 64'(s_ready), 64'(0));
    check("t3_m_valid", 64'(m_valid), 64'(1));
    m_ready = 1'b1;
    #1;
    check("t3_pop_nogrant", 64'(s_ready), 64'(0));
    tick();
    m_ready = 1'b0;
    check("t3_one_more", 64'(s_ready), 64'(4'b0001));
    tick();
    check("t3_blocked2", 64'(s_ready), 64'(0));
    tick();
    check("t3_blocked3", 64'(s_ready), 64'(0));
    m_ready = 1'b1;
    tick();
    check("t3_sim_grant", 64'(s_ready), 64'(4'b0010));
    tick();
    m_ready = 1'b0;
    check("t3_credit_kept", 64'(s_ready), 64'(4'b0100));
    tick();
    check("t3_blocked4", 64'(s_ready), 64'(0));
    s_valid = 4'b0000; m_ready = 1'b1;
    wait_idle("t3_idle");

    // Backpressure: head held stable for 10 cycles.
    do_reset();
    a_val[0] = 16'h0100; b_val[0] = 16'h0011; a_val[1] = 16'h0200; b_val[1] = 16'h0022;
    s_valid = 4'b0011;
    tick(); tick();
    s_valid = 4'b0000;
    n = 0;
    while (!m_valid && n < 20) begin tick(); n++; end
    check("t4_m_valid", 64'(m_valid), 64'(1));
    repeat (10) begin
      check("t4_hold_id", 64'(m_id), 64'(0));
      check("t4_hold_dat", 64'(m_data[16:0]), 64'(17'h111));
      check("t4_hold_top", 64'(m_data[OUT_W-1 -: 17]), 64'(17'h111));
      tick();
    end
    m_ready = 1'b1;
    #1;
    check("t4_tail_pending", 64'(q_id.size()), 64'(2));
    wait_idle("t4_idle");

    // Enable drop with two in flight, then a spurious core strobe.
    do_reset();
    m_ready = 1'b1; s_valid = 4'b1001;
    #1;
    check("t5_g0", 64'(s_ready), 64'(4'b0001));
    tick();
    check("t5_g3", 64'(s_ready), 64'(4'b1000));
    tick();
    enable = 1'b0;
    repeat (8) begin
      #1;
      check("t5_no_grant", 64'(s_ready), 64'(0));
      tick();
    end
    wait_idle("t5_idle");
    check("t5_sb_empty", 64'(q_id.size()), 64'(0));
    s_valid = 4'b0000; spur = 1'b1;
    tick();
    spur = 1'b0;
    check("t5_err_set", 64'(err_unexp), 64'(1));
    check("t5_dropped", 64'(m_valid), 64'(0));
    repeat (3) tick();
    check("t5_err_sticky", 64'(err_unexp), 64'(1));
    enable = 1'b1;

    // Asynchronous reset between edges with three operations in flight.
    m_ready = 1'b0; s_valid = 4'b1111;
    tick(); tick(); tick();
    s_valid = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    check("t6_cin_rdy", 64'(core_in_ready), 64'(0));
    check("t6_cin_dat", 64'(core_in_data[63:0]), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_err", 64'(err_unexp), 64'(0));
    check("t6_m_valid", 64'(m_valid), 64'(0));
    s_valid = 4'b1111;
    #1;
    check("t6_s_ready", 64'(s_ready), 64'(0));
    q_id.delete(); q_dat.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("t6_from0", 64'(s_ready), 64'(4'b0001));
    grants = 0;
    repeat (6) begin
      #1;
      if (s_ready != 4'b0000) grants++;
      tick();
    end
    check("t6_full_credit", 64'(grants), 64'(4));
    s_valid = 4'b0000; m_ready = 1'b1;
    wait_idle("t6_idle");

    check("end_sb_empty", 64'(q_id.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/matrix_add_share_scheduler.md
Name: matrix_add_share_scheduler

Overview:
- Shares one pipelined MatrixAdd core among N_REQ requesters using round-robin arbitration and credit-based flow control.
- Issues operand sets to the core as single-cycle inReady pulses and tags each issue with the requester ID.
- The core cannot stall, so results are buffered in an ID-tagged result FIFO. They are returned on one shared valid/ready output carrying the originating requester ID.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IN_W, 3840, packed operand width per request (A and B matrices).
- OUT_W, 2040, packed sum width from the core.
- CREDITS, 4, maximum operations in flight (core pipeline plus result FIFO); also the result FIFO depth. Power of 2.
- ID_W, 2, requester ID width; must equal clog2(N_REQ).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- enable  in  1  when low, no new grants; in-flight results still drain.
- s_valid  in  N_REQ  per-requester operand valid.
- s_data  in  N_REQ*IN_W  per-requester operands; requester i occupies bits [(i+1)*IN_W-1 : i*IN_W].
- s_ready  out  N_REQ  one-hot grant; combinational.
- core_in_ready  out  1  single-cycle issue pulse to the core's inReady.
- core_in_data  out  IN_W  registered operands to the core.
- core_out_ready  in  1  core result strobe (outReady).
- core_out_data  in  OUT_W  core result.
- m_valid  out  1  result available.
- m_ready  in  1  downstream accept.
- m_data  out  OUT_W  result.
- m_id  out  ID_W  requester ID of m_data.
- busy  out  1  high while credit_cnt != CREDITS.
- err_unexp  out  1  sticky: core result arrived with the tag FIFO empty.

Behaviour:
- Reset (async, reset=1):
  - s_ready=0, core_in_ready=0, core_in_data=0.
  - m_valid=0, m_data=0, m_id=0, err_unexp=0, busy=0.
  - credit_cnt=CREDITS; rr_ptr=N_REQ-1; both FIFOs empty.
  - Reset mid-operation discards all in-flight and buffered results. The core shares this reset.
- Arbitration (combinational):
  - A grant is possible only when enable=1 and credit_cnt>0.
  - Search starts at index (rr_ptr+1) mod N_REQ and grants the first requester with s_valid set.
  - s_ready = one-hot of that index, else 0. Never more than one bit set.
  - Handshake = s_valid[i] & s_ready[i].
- On handshake at cycle t:
  - Register core_in_data <= s_data slice i.
  - Pulse core_in_ready=1 for exactly cycle t+1.
  - Push i into the tag FIFO (depth CREDITS).
  - rr_ptr <= i; credit_cnt decrements.
- Issue rate: back-to-back grants are allowed, one per cycle, while credits remain.
- Core results:
  - core_out_ready=1 with tag FIFO non-empty: pop tag and push {tag, core_out_data} into the result FIFO in the same cycle.
  - core_out_ready=1 with tag FIFO empty: set err_unexp and drop the result.
  - Results return in issue order; the core is in-order.
  - The result FIFO can never overflow because credits bound occupancy.
- Output:
  - m_valid = result FIFO non-empty. m_data and m_id come from the registered head entry.
  - Latency: core_out_ready at cycle u gives m_valid=1 at u+1 when the FIFO was empty.
  - On m_valid & m_ready: pop the FIFO; credit_cnt increments.
  - m_data and m_id stay stable while m_valid=1 and m_ready=0.
- Credit rules:
  - Grant and output pop in the same cycle: credit_cnt unchanged.
  - credit_cnt=0: s_ready=0 for all requesters.
  - credit_cnt never exceeds CREDITS and never wraps below 0.
- enable low mid-stream: stops grants from the next combinational evaluation. Already-issued operations complete and are delivered normally.
- Pointer wrap: rr_ptr=N_REQ-1 makes the search start at 0.

Test Plan (stub core: fixed latency 3, sum = A+B):
- Single request: reset, then s_valid=4'b0100 with operands of 1 and 2 → s_ready=4'b0100 same cycle; core_in_ready one pulse at t+1; m_valid at t+5 with m_id=2, every sum element=3; busy returns to 0 after m_ready.
- Fairness: s_valid=4'b1111 held, m_ready=1 → grant order 0,1,2,3,0,1…; m_id sequence matches; one grant per cycle.
- Credit exhaustion: m_ready=0, all requesters valid → exactly 4 grants, then s_ready=0. Raising m_ready for one cycle → exactly one further grant. The simultaneous grant and pop leaves credit_cnt unchanged.
- Backpressure: hold m_ready=0 for 10 cycles with m_valid=1 → m_data and m_id stable; no results lost; order preserved on release.
- Enable and spurious strobe:
  - Drop enable with 2 operations in flight → no new s_ready; both results still delivered.
  - Force core_out_ready with the tag FIFO empty → err_unexp=1 and remains set until reset.
- Async reset mid-burst: assert reset between clock edges with 3 in flight → all outputs drop immediately to reset values; credit_cnt=4 after release; the next request is served from index 0.
